pattern_gen: RTL and testbench
==============================

# pattern_gen

Video test-pattern source directly downstream of the screen-position counter. Consumes per-pixel coordinates and sync/DE timing, produces RGB pixel data with matched sync/DE through a fixed 2-stage pipeline, and feeds the TMDS/VGA output stage. Pattern selection is frame-synchronous and includes an animated moving bar driven by an internal frame counter.

## Interface
- WIDTH, 10, coordinate width; must match the upstream counter.
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- CB, 4, bits per colour channel.
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  reset; asynchronous, active-high.
- sx  in  WIDTH  current pixel x.
- sy  in  WIDTH  current pixel y.
- hsync_i  in  1  horizontal sync from counter.
- vsync_i  in  1  vertical sync from counter.
- de_i  in  1  data enable from counter.
- pat_sel  in  2  requested pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 moving bar.
- solid_rgb  in  3*CB  requested solid colour {R,G,B}.
- hsync_o  out  1  hsync_i delayed 2 cycles.
- vsync_o  out  1  vsync_i delayed 2 cycles.
- de_o  out  1  de_i delayed 2 cycles.
- r, g, b  out  CB each  pixel colour, aligned with de_o.
- frame_cnt  out  16  completed-frame count, wraps at 65535→0.

## Operation
- Frame boundary: cycle where vsync_i=1 and registered previous vsync_i=0 (rising edge).
- On a frame boundary: pat_sel→pat_act, solid_rgb→rgb_act, frame_cnt+=1, bar_x updated. Changes to pat_sel/solid_rgb at any other time have no effect until the next boundary; value present on the boundary cycle is the one captured.
- bar_x: if bar_x+4 ≥ H_RES then 0, else bar_x+4. Compare in WIDTH+1 bits, no overflow.
- Patterns (evaluated on stage-1 registered coordinates):
  - 0 solid: rgb_act.
  - 1 bars: 8 bars, bar k for k*(H_RES/8) ≤ sx < (k+1)*(H_RES/8); order white, yellow, cyan, green, magenta, red, blue, black; full = all ones. Thresholds are compile-time constants; no divider.
  - 2 checker: white if sx[5]^sy[5], else black (32×32 squares).
  - 3 moving bar: white if bar_x ≤ sx < bar_x+16, else black; no wrap of the bar across right edge.
- r/g/b forced to 0 whenever stage-2 de is 0.
- Reset values: all outputs 0, pat_act=0, rgb_act=0 (black), bar_x=0, frame_cnt=0, previous-vsync register 0, all pipeline registers 0.

## Timing
- Stage 1: register sx, sy, hsync_i, vsync_i, de_i; compute pattern-independent compare results (bar index, bar-hit, checker bit).
- Stage 2: mux by pat_act, apply DE blanking and overlay, register r/g/b and delayed syncs/DE.
- Latency exactly 2 cycles from inputs to all outputs; syncs, DE, RGB always mutually aligned.
- pat_act/rgb_act/bar_x/frame_cnt update on the clock edge of the boundary cycle; first pixel affected is the first active pixel of the following frame (boundary is in vertical blanking).
- Reset mid-frame: outputs clear immediately (asynchronous); after deassertion first meaningful output appears 2 cycles after first valid input; first boundary after reset increments frame_cnt to 1.
- vsync_i held high across reset release: no boundary until it falls and rises again.

## Configuration
- PATTERN_GEN_BORDER_EN defined: when de is active and sx==0, sx==H_RES-1, sy==0 or sy==V_RES-1, r/g/b forced all ones regardless of pattern; same 2-cycle latency.
- Undefined: no overlay logic, pattern output unmodified.

## Test plan
- Reset with pat_sel=0, solid_rgb=12'hF00 held; run 2 frames at 640×480 → frame 1 pixels all 0 (rgb_act black), frame 2 active pixels r=F,g=0,b=0; frame_cnt=2.
- pat_sel=1 → after boundary, sx=0 gives FFF, sx=80 gives FF0, sx=559 gives 00F, sx=560 gives 000; de_o low → 000.
- pat_sel=2 → (sx,sy)=(0,0) 000, (32,0) FFF, (32,32) 000.
- pat_sel=3 over 161 frames → bar at x=0..15 in frame 1, x=4..19 in frame 2; bar_x sequence 636→0 wraps.
- Change pat_sel mid-active-region, and on the exact boundary cycle → no mid-frame change; boundary-cycle value is applied next frame.
- Delay check: compare hsync_o/vsync_o/de_o against inputs → exact 2-cycle delay; assert rst_pix mid-line → all outputs 0 same cycle; with PATTERN_GEN_BORDER_EN, (0,100) and (639,479) give FFF under pattern 2.

Source files
------------

// File: rtl/pattern_gen.sv
// pattern_gen: 2-stage video test-pattern source (solid, colour bars, checker, moving bar).
// Define PATTERN_GEN_BORDER_EN to overlay a white one-pixel border on the active area.
module pattern_gen #(
  parameter int WIDTH = 10,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CB    = 4
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [WIDTH-1:0] sx,
  input  logic [WIDTH-1:0] sy,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
  input  logic [1:0]       pat_sel,
  input  logic [3*CB-1:0]  solid_rgb,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [CB-1:0]    r,
  output logic [CB-1:0]    g,
  output logic [CB-1:0]    b,
  output logic [15:0]      frame_cnt
);
  localparam int BAR_W = H_RES / 8;
  localparam int XW    = WIDTH + 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } tim_t;

  tim_t             tim1_q, tim1_d, tim2_q, tim2_d;
  logic [WIDTH-1:0] sx1_q, sx1_d, sy1_q, sy1_d;
  logic             vs_prev_q, vs_prev_d, arm_q, arm_d;
  logic [1:0]       pat_act_q, pat_act_d;
  logic [3*CB-1:0]  rgb_act_q, rgb_act_d, rgb_q, rgb_d;
  logic [WIDTH-1:0] bar_x_q, bar_x_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_start;
  logic [XW-1:0]    bar_nx, sx1_w, bar_lo;
  logic [2:0]       bar_idx;
  logic             bar_hit, chk;
`ifdef PATTERN_GEN_BORDER_EN
  logic             border;
`endif

  // arm_q blocks a false boundary when vsync_i is already high as reset releases
  always_comb begin
    frame_start = vsync_i && !vs_prev_q && arm_q;
    vs_prev_d   = vsync_i;
    arm_d       = arm_q | ~vsync_i;
    pat_act_d   = pat_act_q;
    rgb_act_d   = rgb_act_q;
    bar_x_d     = bar_x_q;
    frame_cnt_d = frame_cnt_q;
    bar_nx      = XW'(bar_x_q) + XW'(4);
    if (frame_start) begin
      pat_act_d   = pat_sel;
      rgb_act_d   = solid_rgb;
      frame_cnt_d = frame_cnt_q + 16'd1;
      bar_x_d     = (bar_nx >= XW'(H_RES)) ? '0 : bar_nx[WIDTH-1:0];
    end
  end

  always_comb begin
    sx1_d  = sx;
    sy1_d  = sy;
    tim1_d = '{hs: hsync_i, vs: vsync_i, de: de_i};
    tim2_d = tim1_q;
    sx1_w  = XW'(sx1_q);
    bar_lo = XW'(bar_x_q);
    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (sx1_w >= XW'(k * BAR_W)) bar_idx = 3'(k);
    bar_hit = (sx1_w >= bar_lo) && (sx1_w < bar_lo + XW'(16));
    chk     = sx1_q[5] ^ sy1_q[5];
    // bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0]
    case (pat_act_q)
      2'd0:    rgb_d = rgb_act_q;
      2'd1:    rgb_d = {{CB{~bar_idx[1]}}, {CB{~bar_idx[2]}}, {CB{~bar_idx[0]}}};
      2'd2:    rgb_d = {(3*CB){chk}};
      default: rgb_d = {(3*CB){bar_hit}};
    endcase
`ifdef PATTERN_GEN_BORDER_EN
    border = (sx1_q == '0) || (sx1_q == WIDTH'(H_RES - 1)) ||
             (sy1_q == '0) || (sy1_q == WIDTH'(V_RES - 1));
    if (border) rgb_d = '1;
`endif
    if (!tim1_q.de) rgb_d = '0;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      tim1_q      <= '0;
      tim2_q      <= '0;
      sx1_q       <= '0;
      sy1_q       <= '0;
      vs_prev_q   <= 1'b0;
      arm_q       <= 1'b0;
      pat_act_q   <= '0;
      rgb_act_q   <= '0;
      rgb_q       <= '0;
      bar_x_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      tim1_q      <= tim1_d;
      tim2_q      <= tim2_d;
      sx1_q       <= sx1_d;
      sy1_q       <= sy1_d;
      vs_prev_q   <= vs_prev_d;
      arm_q       <= arm_d;
      pat_act_q   <= pat_act_d;
      rgb_act_q   <= rgb_act_d;
      rgb_q       <= rgb_d;
      bar_x_q     <= bar_x_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hsync_o   = tim2_q.hs;
  assign vsync_o   = tim2_q.vs;
  assign de_o      = tim2_q.de;
  assign r         = rgb_q[3*CB-1:2*CB];
  assign g         = rgb_q[2*CB-1:CB];
  assign b         = rgb_q[CB-1:0];
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: vector table for patterns plus sequences for
// reset, frame-synchronous selection, moving bar wrap and pipeline delay.
module tb_pattern_gen;
  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [9:0]  sx, sy;
  logic        hsync_i, vsync_i, de_i;
  logic [1:0]  pat_sel;
  logic [11:0] solid_rgb;
  logic        hsync_o, vsync_o, de_o;
  logic [3:0]  r, g, b;
  logic [15:0] frame_cnt;

  pattern_gen dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
    .pat_sel(pat_sel), .solid_rgb(solid_rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .r(r), .g(g), .b(b), .frame_cnt(frame_cnt)
  );

  always #5 clk_pix = ~clk_pix;

`ifdef PATTERN_GEN_BORDER_EN
  localparam logic [11:0] BRD = 12'hFFF;
`else
  localparam logic [11:0] BRD = 12'h000;
`endif

  typedef struct {
    logic [1:0]  pat;
    logic [11:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic [11:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int m_frames, m_bar;
  logic m_prev, m_arm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_frames = 0; m_bar = 0; m_prev = 1'b0; m_arm = 1'b0;
  endtask

  // one clock with the given inputs; the reference frame counter follows vsync edges
  task automatic cyc(input logic [9:0] x, input logic [9:0] y,
                     input logic hs, input logic vs, input logic de);
    sx = x; sy = y; hsync_i = hs; vsync_i = vs; de_i = de;
    @(posedge clk_pix); #1;
    if (vs && !m_prev && m_arm) begin
      m_frames = (m_frames + 1) % 65536;
      m_bar = (m_bar + 4 >= 640) ? 0 : m_bar + 4;
    end
    if (!vs) m_arm = 1'b1;
    m_prev = vs;
  endtask

  task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                     input logic de, input logic [11:0] exp);
    cyc(x, y, 1'b0, 1'b0, de);
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    check(name, {r, g, b}, exp);
  endtask

  task automatic boundary();
    cyc(10'd0, 10'd500, 1'b0, 1'b1, 1'b0);
    cyc(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t tv[22];
  logic [2:0] hist[$];
  logic [2:0] cur;

  initial begin
    tv[0]  = '{2'd0, 12'hF00, 10'd5,   10'd5,   1'b1, 12'hF00};
    tv[1]  = '{2'd0, 12'h5A3, 10'd100, 10'd200, 1'b1, 12'h5A3};
    tv[2]  = '{2'd0, 12'h5A3, 10'd100, 10'd200, 1'b0, 12'h000};
    tv[3]  = '{2'd1, 12'h000, 10'd0,   10'd100, 1'b1, 12'hFFF};
    tv[4]  = '{2'd1, 12'h000, 10'd79,  10'd100, 1'b1, 12'hFFF};
    tv[5]  = '{2'd1, 12'h000, 10'd80,  10'd100, 1'b1, 12'hFF0};
    tv[6]  = '{2'd1, 12'h000, 10'd160, 10'd100, 1'b1, 12'h0FF};
    tv[7]  = '{2'd1, 12'h000, 10'd240, 10'd100, 1'b1, 12'h0F0};
    tv[8]  = '{2'd1, 12'h000, 10'd320, 10'd100, 1'b1, 12'hF0F};
    tv[9]  = '{2'd1, 12'h000, 10'd400, 10'd100, 1'b1, 12'hF00};
    tv[10] = '{2'd1, 12'h000, 10'd559, 10'd100, 1'b1, 12'h00F};
    tv[11] = '{2'd1, 12'h000, 10'd560, 10'd100, 1'b1, 12'h000};
    tv[12] = '{2'd1, 12'h000, 10'd639, 10'd100, 1'b1, BRD};
    tv[13] = '{2'd1, 12'h000, 10'd300, 10'd100, 1'b0, 12'h000};
    tv[14] = '{2'd2, 12'h000, 10'd0,   10'd0,   1'b1, BRD};
    tv[15] = '{2'd2, 12'h000, 10'd32,  10'd1,   1'b1, 12'hFFF};
    tv[16] = '{2'd2, 12'h000, 10'd32,  10'd32,  1'b1, 12'h000};
    tv[17] = '{2'd2, 12'h000, 10'd1,   10'd32,  1'b1, 12'hFFF};
    tv[18] = '{2'd2, 12'h000, 10'd64,  10'd64,  1'b1, 12'h000};
    tv[19] = '{2'd2, 12'h000, 10'd0,   10'd100, 1'b1, 12'hFFF};
    tv[20] = '{2'd2, 12'h000, 10'd639, 10'd479, 1'b1, 12'hFFF};
    tv[21] = '{2'd2, 12'h000, 10'd64,  10'd479, 1'b1, BRD};

    // reset with vsync held high across release
    rst_pix = 1'b1; sx = '0; sy = '0; hsync_i = 0; vsync_i = 1'b1; de_i = 0;
    pat_sel = 2'd0; solid_rgb = 12'hF00;
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    check("reset_outputs", {hsync_o, vsync_o, de_o, r, g, b}, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    rst_pix = 1'b0;
    cyc(10'd5, 10'd5, 1'b0, 1'b1, 1'b1);
    cyc(10'd5, 10'd5, 1'b0, 1'b1, 1'b1);
    check("frame1_black", {de_o, r, g, b}, 13'h1000);
    cyc(10'd5, 10'd5, 1'b0, 1'b1, 1'b1);
    check("no_boundary_held_vsync", frame_cnt, 0);
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    boundary();
    check("first_boundary_cnt", frame_cnt, 1);
    pix("frame2_red", 10'd5, 10'd5, 1'b1, 12'hF00);
    boundary();
    check("frame_cnt_2", frame_cnt, 2);

    // pattern table, one frame per vector
    for (int i = 0; i < 22; i++) begin
      pat_sel = tv[i].pat; solid_rgb = tv[i].rgb;
      boundary();
      pix($sformatf("vec%0d", i), tv[i].x, tv[i].y, tv[i].de, tv[i].exp);
    end
    check("frame_cnt_table", frame_cnt, 16'(m_frames));

    // selection only changes at a boundary; the boundary-cycle value wins
    pat_sel = 2'd1; boundary();
    pix("bars_40", 10'd40, 10'd100, 1'b1, 12'hFFF);
    pat_sel = 2'd2;
    pix("midframe_ignored", 10'd40, 10'd100, 1'b1, 12'hFFF);
    pat_sel = 2'd1;
    cyc(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    pat_sel = 2'd2;
    cyc(10'd0, 10'd500, 1'b0, 1'b1, 1'b0);
    pat_sel = 2'd1;
    cyc(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    pix("boundary_value_applied", 10'd40, 10'd100, 1'b1, 12'h000);

    // moving bar: align to bar_x=0, step once, then walk to the wrap
    pat_sel = 2'd3; boundary();
    for (int n = 0; n < 200 && m_bar != 0; n++) boundary();
    pix("bar0_x0",  10'd0,  10'd100, 1'b1, 12'hFFF);
    pix("bar0_x15", 10'd15, 10'd100, 1'b1, 12'hFFF);
    pix("bar0_x16", 10'd16, 10'd100, 1'b1, 12'h000);
    boundary();
    pix("bar4_x3",  10'd3,  10'd100, 1'b1, 12'h000);
    pix("bar4_x4",  10'd4,  10'd100, 1'b1, 12'hFFF);
    pix("bar4_x19", 10'd19, 10'd100, 1'b1, 12'hFFF);
    pix("bar4_x20", 10'd20, 10'd100, 1'b1, 12'h000);
    for (int n = 0; n < 158; n++) boundary();
    pix("bar636_x635", 10'd635, 10'd100, 1'b1, 12'h000);
    pix("bar636_x636", 10'd636, 10'd100, 1'b1, 12'hFFF);
    pix("bar636_x639", 10'd639, 10'd100, 1'b1, 12'hFFF);
    boundary();
    pix("wrap_x0",   10'd0,   10'd100, 1'b1, 12'hFFF);
    pix("wrap_x636", 10'd636, 10'd100, 1'b1, 12'h000);
    check("frame_cnt_bar", frame_cnt, 16'(m_frames));

    // exact two-cycle delay of hsync/vsync/de
    hist.delete();
    for (int i = 0; i < 40; i++) begin
      cur = 3'($urandom_range(0, 7));
      hist.push_back(cur);
      cyc(10'(i), 10'd200, cur[2], cur[1], cur[0]);
      if (i >= 1) check($sformatf("delay%0d", i), {hsync_o, vsync_o, de_o}, hist[i-1]);
    end
    check("frame_cnt_delay", frame_cnt, 16'(m_frames));

    // asynchronous reset mid-line
    pat_sel = 2'd0; solid_rgb = 12'hFFF; boundary();
    cyc(10'd10, 10'd100, 1'b1, 1'b0, 1'b1);
    cyc(10'd11, 10'd100, 1'b1, 1'b0, 1'b1);
    check("pre_reset_active", {hsync_o, de_o, r, g, b}, 14'h3FFF);
    #2 rst_pix = 1'b1;
    #1;
    check("async_reset_clear", {hsync_o, vsync_o, de_o, r, g, b, frame_cnt}, 0);
    @(negedge clk_pix);
    rst_pix = 1'b0;
    model_reset();
    cyc(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    boundary();
    check("post_reset_cnt", frame_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
